fp_alu_issuer: RTL

Sequential front end for the combinational 64-bit floating-point ALU. It takes operation commands (R, S, Op, tag) over a valid/ready interface and buffers them in a small FIFO. For each command it drives the ALU operand registers, holds them stable for a programmable settle time, then captures Y and the 6-bit Status. Each result is returned on a valid/ready response port, and the last Status is kept as an architectural flags register for the execution unit's branch logic.

---
 rtl/fp_alu_issuer_if.sv | 30 +++
 rtl/fp_alu_issuer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fp_alu_issuer_if.sv
// Command and response handshake channels of the FP ALU issuer.
// The issuer is the slave: it accepts commands and returns results.
interface fp_alu_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_r;
  logic [63:0] cmd_s;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_tag;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_y;
  logic [5:0]  rsp_status;
  logic [3:0]  rsp_tag;

  modport master (
    output cmd_valid, cmd_r, cmd_s, cmd_op, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_y, rsp_status, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_r, cmd_s, cmd_op, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_y, rsp_status, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/fp_alu_issuer.sv
// Sequential front end for the combinational 64-bit FP ALU: buffers commands,
// holds ALU operands for SETTLE cycles, captures Y/Status and returns them in order.
module fp_alu_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fp_alu_issuer_if.slave           bus,
  output logic [63:0]              alu_r,
  output logic [63:0]              alu_s,
  output logic [3:0]               alu_op,
  input  logic [63:0]              alu_y,
  input  logic [5:0]               alu_status,
  output logic [5:0]               flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] r;
    logic [63:0] s;
    logic [3:0]  op;
    logic [3:0]  tag;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t        state;
  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    settle_cnt;
  logic [3:0]    tag_q;
  logic          push;
  logic          pop;

  assign cmd_in        = '{r: bus.cmd_r, s: bus.cmd_s, op: bus.cmd_op, tag: bus.cmd_tag};
  assign head          = mem[rd_ptr];
  assign bus.cmd_ready = (count < CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // The FSM is the only consumer: pop from IDLE, or from HOLD on the response handshake.
  assign pop           = (count != '0) &&
                         ((state == ST_IDLE) || ((state == ST_HOLD) && bus.rsp_ready));
  assign busy          = (state != ST_IDLE) || (count != '0);

  // NOTE: FIFO storage has no reset; occupancy is governed by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      alu_r          <= '0;
      alu_s          <= '0;
      alu_op         <= '0;
      tag_q          <= '0;
      settle_cnt     <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_y      <= '0;
      bus.rsp_status <= '0;
      bus.rsp_tag    <= '0;
      flags          <= '0;
    end else begin
      // Operands change only here, so they stay put through SETTLE and HOLD.
      if (pop) begin
        alu_r      <= head.r;
        alu_s      <= head.s;
        alu_op     <= head.op;
        tag_q      <= head.tag;
        settle_cnt <= 4'(SETTLE);
      end

      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            bus.rsp_y      <= alu_y;
            bus.rsp_status <= alu_status;
            bus.rsp_tag    <= tag_q;
            flags          <= alu_status;
            bus.rsp_valid  <= 1'b1;
            state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= pop ? ST_SETTLE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
